uart_cmd_rx: RTL and testbench

Serial command receiver that sits directly upstream of the command parser. It deserialises 8N1 UART frames from the host line and drives the parser's 8-bit `cmd` bus. The bit rate is selected by the parser's own `baud_rate` output, which closes the loop. Each good frame updates `cmd` and raises a one-cycle strobe; bad frames are dropped and flagged.

---
 rtl/xc_uart_pkg.sv | 26 ++
 rtl/uart_cmd_rx_bit_timer.sv | 28 ++
 rtl/uart_cmd_rx.sv | 143 ++++++++++++++
 tb/tb_uart_cmd_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/xc_uart_pkg.sv
// Shared UART receive definitions: FSM states, 8N1 frame shape and
// the bit-period arithmetic also used by the host-side TX model.
package xc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int unsigned bit_period(
    input int unsigned base,
    input int unsigned minp,
    input logic [3:0]  br
  );
    int unsigned raw;
    raw = base >> br;
    return (raw < minp) ? minp : raw;
  endfunction

endpackage

// File: rtl/uart_cmd_rx_bit_timer.sv
// Loadable bit-period down-counter; loads a full or half period
// and flags zero.
module bit_timer #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          half,
  input  logic [CW-1:0] period_q,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= half ? (period_q >> 1) - CW'(1) : period_q - CW'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 serial command receiver feeding the parser's cmd bus; bit rate
// is selected by the parser's baud_rate output.
module uart_cmd_rx
  import xc_uart_pkg::*;
#(
  parameter int BASE_DIVIDER = 1024,
  parameter int MIN_DIVIDER  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] baud_rate,
  output logic [7:0] cmd,
  output logic       cmd_strobe,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(BASE_DIVIDER) + 1;

  logic          s1, s2, s3;
  logic [1:0]    warm;
  logic          fall;
  state_t        state, state_d;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [CW-1:0] period_q;
  logic          load, half, zero;
  logic          take, good, bad;

  // The edge flop only arms once s2 carries a real line sample, so a
  // line already low when reset releases is not taken as a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s3   <= 1'b0;
      warm <= 2'b00;
    end else begin
      s1   <= rx;
      s2   <= s1;
      s3   <= s2 & warm[1];
      warm <= {warm[0], 1'b1};
    end
  end

  assign fall = s3 & ~s2;

  bit_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .half     (half),
    .period_q (period_q),
    .zero     (zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    half    = 1'b0;
    take    = 1'b0;
    good    = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          load    = 1'b1;
          half    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (zero) begin
          if (!s2) begin
            load    = 1'b1;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (zero) begin
          load = 1'b1;
          take = 1'b1;
          if (idx == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (zero) begin
          if (s2) begin
            good    = 1'b1;
            state_d = IDLE;
          end else begin
            bad     = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (s2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // period_q tracks baud_rate while idle and freezes for the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q      <= '0;
      idx           <= '0;
      shreg         <= '0;
      cmd           <= '0;
      cmd_strobe    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (state == IDLE) begin
        period_q <= CW'(bit_period(BASE_DIVIDER, MIN_DIVIDER, baud_rate));
      end
      if (state == START) begin
        idx <= '0;
      end else if (take) begin
        idx <= idx + 3'd1;
      end
      if (take) shreg <= {s2, shreg[7:1]};
      if (good) cmd <= shreg;
      cmd_strobe    <= good;
      framing_error <= bad;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at BASE_DIVIDER=64: table of frames
// plus hand sequences for back-to-back, glitch, rate change and reset.
module tb_uart_cmd_rx;
  import xc_uart_pkg::*;

  localparam int BASE = 64;
  localparam int MINP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] baud_rate = 4'd2;
  logic [7:0] cmd;
  logic       cmd_strobe, framing_error, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_strobe = 0, n_ferr = 0, n_both = 0, n_wide = 0;
  int strobe_cyc = 0, start_cyc = 0;
  logic prev_s = 1'b0, prev_f = 1'b0;
  logic [7:0] got[$];

  typedef struct {
    logic [7:0] data;
    bit         stop;
    logic [3:0] baud;
    int         exp_strobe;
    int         exp_ferr;
    logic [7:0] exp_cmd;
  } vec_t;

  vec_t vt[7];

  always #5 clk = ~clk;

  uart_cmd_rx #(.BASE_DIVIDER(BASE), .MIN_DIVIDER(MINP)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .baud_rate     (baud_rate),
    .cmd           (cmd),
    .cmd_strobe    (cmd_strobe),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cmd_strobe) begin
      n_strobe++;
      strobe_cyc = cyc;
      got.push_back(cmd);
    end
    if (framing_error) n_ferr++;
    if (cmd_strobe && framing_error) n_both++;
    if ((cmd_strobe && prev_s) || (framing_error && prev_f)) n_wide++;
    prev_s = cmd_strobe;
    prev_f = framing_error;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input int p, input bit chg,
                            input logic [3:0] nb);
    rx = 1'b0;
    start_cyc = cyc;
    idle(p);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (chg && i == 4) baud_rate = nb;
      idle(p);
    end
    rx = stop;
    idle(p);
    if (!stop) idle(40);
    rx = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, p;
    vt[0] = '{8'h31, 1'b1, 4'd2,  1, 0, 8'h31};
    vt[1] = '{8'h55, 1'b0, 4'd2,  0, 1, 8'h31};
    vt[2] = '{8'hA4, 1'b1, 4'd2,  1, 0, 8'hA4};
    vt[3] = '{8'h00, 1'b1, 4'd3,  1, 0, 8'h00};
    vt[4] = '{8'hFF, 1'b1, 4'd0,  1, 0, 8'hFF};
    vt[5] = '{8'h96, 1'b1, 4'd15, 1, 0, 8'h96};
    vt[6] = '{8'h5A, 1'b1, 4'd4,  1, 0, 8'h5A};

    idle(3);
    chk("reset_cmd", int'(cmd), 0);
    chk("reset_strobe", int'(cmd_strobe), 0);
    chk("reset_ferr", int'(framing_error), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    idle(6);

    // basic byte with latency window
    s0 = n_strobe;
    send_frame(8'h31, 1'b1, 16, 1'b0, 4'd0);
    idle(20);
    chk("basic_strobes", n_strobe - s0, 1);
    chk("basic_cmd", int'(cmd), 8'h31);
    chk("basic_latency_ok",
        int'((strobe_cyc - start_cyc) >= 150 &&
             (strobe_cyc - start_cyc) <= 162), 1);
    chk("basic_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      baud_rate = vt[i].baud;
      idle(4);
      p = int'(bit_period(BASE, MINP, vt[i].baud));
      s0 = n_strobe;
      f0 = n_ferr;
      send_frame(vt[i].data, vt[i].stop, p, 1'b0, 4'd0);
      idle(3 * p);
      chk($sformatf("vec%0d_strobes", i), n_strobe - s0, vt[i].exp_strobe);
      chk($sformatf("vec%0d_ferr", i), n_ferr - f0, vt[i].exp_ferr);
      chk($sformatf("vec%0d_cmd", i), int'(cmd), int'(vt[i].exp_cmd));
      chk($sformatf("vec%0d_busy", i), int'(busy), 0);
    end

    // back-to-back, no idle gap
    baud_rate = 4'd2;
    idle(4);
    got.delete();
    f0 = n_ferr;
    send_frame(8'h02, 1'b1, 16, 1'b0, 4'd0);
    send_frame(8'h1D, 1'b1, 16, 1'b0, 4'd0);
    send_frame(8'h83, 1'b1, 16, 1'b0, 4'd0);
    idle(40);
    chk("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_0", int'(got[0]), 8'h02);
      chk("b2b_1", int'(got[1]), 8'h1D);
      chk("b2b_2", int'(got[2]), 8'h83);
    end
    chk("b2b_ferr", n_ferr - f0, 0);

    // glitch rejection
    s0 = n_strobe;
    rx = 1'b0;
    idle(5);
    chk("glitch_busy_high", int'(busy), 1);
    rx = 1'b1;
    idle(12);
    chk("glitch_busy_low", int'(busy), 0);
    idle(200);
    chk("glitch_strobes", n_strobe - s0, 0);

    // rate change mid-frame, then new rate, then clamp
    baud_rate = 4'd2;
    idle(4);
    send_frame(8'h23, 1'b1, 16, 1'b1, 4'd3);
    idle(20);
    chk("rate_old_cmd", int'(cmd), 8'h23);
    send_frame(8'h6E, 1'b1, 8, 1'b0, 4'd0);
    idle(20);
    chk("rate_new_cmd", int'(cmd), 8'h6E);
    baud_rate = 4'd15;
    idle(4);
    send_frame(8'hC3, 1'b1, 8, 1'b0, 4'd0);
    idle(20);
    chk("rate_clamp_cmd", int'(cmd), 8'hC3);

    // reset during data bit 4
    baud_rate = 4'd2;
    idle(4);
    s0 = n_strobe;
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hB7 >> i) & 8'h01;
      idle(16);
    end
    rx = 1'b1;
    idle(8);
    reset = 1'b1;
    #1;
    chk("rst_mid_cmd", int'(cmd), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_strobe", int'(cmd_strobe), 0);
    chk("rst_mid_ferr", int'(framing_error), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(40);
    chk("rst_mid_no_strobe", n_strobe - s0, 0);
    send_frame(8'h4C, 1'b1, 16, 1'b0, 4'd0);
    idle(30);
    chk("rst_after_cmd", int'(cmd), 8'h4C);
    chk("rst_after_strobes", n_strobe - s0, 1);

    chk("never_both", n_both, 0);
    chk("pulse_width", n_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
